// File: rtl/mem_access_stage.sv
// MEM pipeline stage: negedge-clocked req/ack handshake to a variable-latency data memory,
// stall generation and MEM/WB payload register. Optional macro MEM_TIMEOUT_EN adds a WAIT timeout abort.
module mem_access_stage #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemToReg_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] RD3_in,
  input  logic [REG_W-1:0]  RR3_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              RegWrite_wb,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  RR3_wb,
  output logic              mem_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]        r_state;
  logic              r_memReq;
  logic              r_memWe;
  logic [DATA_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_regWriteWb;
  logic [DATA_W-1:0] r_wbData;
  logic [REG_W-1:0]  r_rr3Wb;
  logic              r_memErr;
  logic              r_latRegWrite;
  logic              r_latMemToReg;
  logic [REG_W-1:0]  r_latRr3;

  logic              w_access;
  logic              w_misaligned;
  logic              w_timeout;

  assign w_access     = MemRead_in | MemWrite_in;
  assign w_misaligned = w_access & (alu_in[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  // Counts WAIT edges without ack; zero on the first WAIT edge, so expiry lands on edge TIMEOUT_CYCLES.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_tmoCnt;

  assign w_timeout = (r_state == ST_WAIT) & ~mem_ack &
                     (r_tmoCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_tmoCnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_tmoCnt <= '0;
    end else if (!mem_ack && !w_timeout) begin
      r_tmoCnt <= r_tmoCnt + 1'b1;
    end
  end
`else
  logic [31:0] w_unusedTimeout;

  assign w_unusedTimeout = 32'(TIMEOUT_CYCLES);
  assign w_timeout       = 1'b0;
`endif

  // Low on the ack (or abort) edge so EX/MEM advances on the same edge the access retires.
  assign stall = ((r_state == ST_IDLE) & w_access & ~w_misaligned) |
                 ((r_state == ST_WAIT) & ~mem_ack & ~w_timeout);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_memReq      <= 1'b0;
      r_memWe       <= 1'b0;
      r_memAddr     <= '0;
      r_memWdata    <= '0;
      r_regWriteWb  <= 1'b0;
      r_wbData      <= '0;
      r_rr3Wb       <= '0;
      r_memErr      <= 1'b0;
      r_latRegWrite <= 1'b0;
      r_latMemToReg <= 1'b0;
      r_latRr3      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_access) begin
            r_regWriteWb <= RegWrite_in;
            r_wbData     <= alu_in;
            r_rr3Wb      <= RR3_in;
          end else if (w_misaligned) begin
            r_regWriteWb <= 1'b0;
            r_memErr     <= 1'b1;
          end else begin
            r_state       <= ST_WAIT;
            r_memReq      <= 1'b1;
            r_memWe       <= MemWrite_in;
            r_memAddr     <= alu_in;
            r_memWdata    <= RD3_in;
            r_latRegWrite <= RegWrite_in;
            r_latMemToReg <= MemToReg_in;
            r_latRr3      <= RR3_in;
            r_regWriteWb  <= 1'b0;
          end
        end
        default: begin
          if (mem_ack) begin
            r_state      <= ST_IDLE;
            r_memReq     <= 1'b0;
            r_regWriteWb <= r_latRegWrite;
            r_rr3Wb      <= r_latRr3;
            r_wbData     <= r_latMemToReg ? mem_rdata : r_memAddr;
          end else if (w_timeout) begin
            r_state      <= ST_IDLE;
            r_memReq     <= 1'b0;
            r_memErr     <= 1'b1;
            r_regWriteWb <= 1'b0;
          end else begin
            r_regWriteWb <= 1'b0;
          end
        end
      endcase
    end
  end

  assign mem_req     = r_memReq;
  assign mem_we      = r_memWe;
  assign mem_addr    = r_memAddr;
  assign mem_wdata   = r_memWdata;
  assign RegWrite_wb = r_regWriteWb;
  assign wb_data     = r_wbData;
  assign RR3_wb      = r_rr3Wb;
  assign mem_err     = r_memErr;

endmodule
